pid_sequencer: RTL

PID_SEQUENCER -- requirements
Module: pid_sequencer

---
 rtl/pid_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pid_sequencer.sv
`timescale 1ns/1ps
// Line-follower PID sequencer: arms on a stable line, gates PID error samples
// with a minimum spacing, and halts after a prolonged line loss.
module pid_sequencer #(
   parameter int ARM_CYC  = 8,
   parameter int ERR_GAP  = 4,
   parameter int LOST_TMO = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_vld,
   input  logic [1:0] cmd,
   output logic       cmd_rdy,
   input  logic       line_present,
   input  logic       smpl_done,
   output logic       go,
   output logic       err_vld,
   output logic [2:0] state,
   output logic       lost_evt,
   output logic [7:0] drop_cnt
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      RUN  = 3'd2,
      LOST = 3'd3,
      HALT = 3'd4
   } state_t;

   localparam int AW = $clog2(ARM_CYC + 1);
   localparam int GW = $clog2(ERR_GAP + 1);
   localparam int LW = $clog2(LOST_TMO + 1);
   localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_CYC - 1);
   localparam logic [GW-1:0] GAP_LOAD  = GW'(ERR_GAP - 1);
   localparam logic [LW-1:0] LOST_LAST = LW'(LOST_TMO - 1);

   state_t        state_q;
   logic [AW-1:0] arm_cnt;
   logic [GW-1:0] gap_cnt;
   logic [LW-1:0] lost_cnt;
   logic          accept;
   logic          is_go;
   logic          is_stop;

   // Handshake: a command transfers on an edge where cmd_vld && cmd_rdy; the
   // sequencer then drops cmd_rdy for exactly one cycle before accepting again.
   assign accept  = cmd_vld & cmd_rdy;
   assign is_go   = accept & (cmd == 2'b01);
   assign is_stop = accept & (cmd == 2'b10);
   assign state   = state_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cmd_rdy  <= 1'b0;
         go       <= 1'b0;
         err_vld  <= 1'b0;
         lost_evt <= 1'b0;
         drop_cnt <= '0;
         arm_cnt  <= '0;
         gap_cnt  <= '0;
         lost_cnt <= '0;
      end else begin
         cmd_rdy  <= ~accept;
         err_vld  <= 1'b0;
         lost_evt <= 1'b0;
         if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);

         case (state_q)
            IDLE: begin
               go <= 1'b0;
               if (is_go) begin
                  state_q  <= ARM;
                  drop_cnt <= '0;
                  arm_cnt  <= '0;
               end
            end
            ARM: begin
               if (is_stop) begin
                  state_q <= IDLE;
               end else if (!line_present) begin
                  arm_cnt <= '0;
               end else if (arm_cnt == ARM_LAST) begin
                  state_q <= RUN;
                  go      <= 1'b1;
               end else begin
                  arm_cnt <= arm_cnt + AW'(1);
               end
            end
            RUN: begin
               if (is_stop) begin
                  state_q <= IDLE;
                  go      <= 1'b0;
               end else if (!line_present) begin
                  state_q  <= LOST;
                  lost_cnt <= '0;
               end else if (smpl_done) begin
                  // A sample inside the spacing window is discarded, not deferred.
                  if (gap_cnt == '0) begin
                     err_vld <= 1'b1;
                     gap_cnt <= GAP_LOAD;
                  end else if (drop_cnt != 8'hff) begin
                     drop_cnt <= drop_cnt + 8'd1;
                  end
               end
            end
            LOST: begin
               if (is_stop) begin
                  state_q <= IDLE;
                  go      <= 1'b0;
               end else if (line_present) begin
                  state_q <= RUN;
               end else if (lost_cnt == LOST_LAST) begin
                  state_q  <= HALT;
                  go       <= 1'b0;
                  lost_evt <= 1'b1;
               end else begin
                  lost_cnt <= lost_cnt + LW'(1);
               end
            end
            HALT: begin
               go <= 1'b0;
               if (is_stop) state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               go      <= 1'b0;
            end
         endcase
      end
   end

endmodule
